// File: rtl/pong_pixel_gen.sv
// pong_pixel_gen: VGA display stage for the pong game.
//   Generates display timing on the pixel clock, snapshots ball and paddle
//   positions once per frame at the start of vertical blanking, and draws
//   the ball and paddle. frame_tick_o pulses once per frame and serves as the
//   game-logic update strobe.
// Ports:
//   clk_pix_i     pixel clock (only clock)
//   rst_n_i       asynchronous active-low reset
//   ball_i        {pos_x[9:0], pos_y[9:0]} ball top-left corner
//   pad_i         {pos_x[9:0], pos_y[9:0]} paddle; only pos_y is used
//   frame_tick_o  1-cycle pulse at start of vertical blanking
//   hsync_o       horizontal sync, active-low
//   vsync_o       vertical sync, active-low
//   de_o          data enable, high in the visible area
//   rgb_o         {r,g,b} pixel colour, 0 outside the visible area
module pong_pixel_gen #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned BALL_SIZE = 8,
  parameter int unsigned PAD_X     = 16,
  parameter int unsigned PAD_W     = 8,
  parameter int unsigned PAD_H     = 64
) (
  input  logic        clk_pix_i,
  input  logic        rst_n_i,
  input  logic [19:0] ball_i,
  input  logic [19:0] pad_i,
  output logic        frame_tick_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        de_o,
  output logic [2:0]  rgb_o
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  // ---------------- S0: counters and per-frame snapshot ----------------
  logic [9:0] h_q, h_d, v_q, v_d;
  logic [9:0] ball_x_q, ball_y_q, pad_y_q;
  logic       snap_en;

  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == 10'(H_TOTAL - 1)) begin
      h_d = '0;
      v_d = (v_q == 10'(V_TOTAL - 1)) ? '0 : v_q + 10'd1;
    end
    snap_en = (h_q == '0) && (v_q == 10'(V_ACTIVE));
  end

  always_ff @(posedge clk_pix_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      h_q      <= '0;
      v_q      <= '0;
      ball_x_q <= '0;
      ball_y_q <= '0;
      pad_y_q  <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
      if (snap_en) begin
        ball_x_q <= ball_i[19:10];
        ball_y_q <= ball_i[9:0];
        pad_y_q  <= pad_i[9:0];
      end
    end
  end

  // Paddle x is fixed by PAD_X, so the paddle's x input is intentionally ignored.
  logic unused_pad_x;
  assign unused_pad_x = ^pad_i[19:10];

  // ---------------- S1: registered compares ----------------
  // Hit tests are widened to 11 bits so a ball near x/y=1023 does not wrap
  // around onto the left/top edge of the screen.
  logic [10:0] h_ext, v_ext, bx, by, py;
  logic        ball_hit, pad_hit, vis, hs_act, vs_act;

  always_comb begin
    h_ext    = {1'b0, h_q};
    v_ext    = {1'b0, v_q};
    bx       = {1'b0, ball_x_q};
    by       = {1'b0, ball_y_q};
    py       = {1'b0, pad_y_q};
    ball_hit = (h_ext >= bx) && (h_ext < bx + 11'(BALL_SIZE)) &&
               (v_ext >= by) && (v_ext < by + 11'(BALL_SIZE));
    pad_hit  = (h_ext >= 11'(PAD_X)) && (h_ext < 11'(PAD_X + PAD_W)) &&
               (v_ext >= py) && (v_ext < py + 11'(PAD_H));
    vis      = (h_q < 10'(H_ACTIVE)) && (v_q < 10'(V_ACTIVE));
    hs_act   = (h_q >= 10'(HS_START)) && (h_q < 10'(HS_END));
    vs_act   = (v_q >= 10'(VS_START)) && (v_q < 10'(VS_END));
  end

  logic de1_q, hs1_q, vs1_q, tick1_q, ball1_q, pad1_q;

  always_ff @(posedge clk_pix_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      de1_q   <= 1'b0;
      hs1_q   <= 1'b1;
      vs1_q   <= 1'b1;
      tick1_q <= 1'b0;
      ball1_q <= 1'b0;
      pad1_q  <= 1'b0;
    end else begin
      de1_q   <= vis;
      hs1_q   <= ~hs_act;
      vs1_q   <= ~vs_act;
      tick1_q <= snap_en;
      ball1_q <= ball_hit;
      pad1_q  <= pad_hit;
    end
  end

  // ---------------- S2: output registers ----------------
  always_ff @(posedge clk_pix_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      frame_tick_o <= 1'b0;
      hsync_o      <= 1'b1;
      vsync_o      <= 1'b1;
      de_o         <= 1'b0;
      rgb_o        <= '0;
    end else begin
      frame_tick_o <= tick1_q;
      hsync_o      <= hs1_q;
      vsync_o      <= vs1_q;
      de_o         <= de1_q;
      if (!de1_q)       rgb_o <= 3'b000;
      else if (ball1_q) rgb_o <= 3'b111;
      else if (pad1_q)  rgb_o <= 3'b010;
      else              rgb_o <= 3'b000;
    end
  end

endmodule

// File: tb/tb_pong_pixel_gen.sv
// Testbench for pong_pixel_gen. A reduced-geometry instance is checked every
// cycle against a frame/pixel arithmetic model over several frames with
// directed and random ball/paddle positions, plus a mid-frame reset. A
// full-size instance checks the standard 640x480 timing over the first lines.
module tb_pong_pixel_gen;

  // reduced geometry: 80 x 55 = 4400 cycles per frame
  localparam int HA = 64, HFP = 4, HSY = 8, HBP = 4;
  localparam int VA = 48, VFP = 2, VSY = 2, VBP = 3;
  localparam int PH = 16;
  localparam int FT = (HA + HFP + HSY + HBP) * (VA + VFP + VSY + VBP);
  localparam int SNAP = VA * (HA + HFP + HSY + HBP);
  localparam logic [6:0] RST_VAL = 7'b0110000;  // tick,hs,vs,de,rgb[2:0]

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [19:0] ball_s = '0, pad_s = '0;
  logic [19:0] ball_f = '0, pad_f = '0;
  logic        tick_s, hs_s, vs_s, de_s, tick_f, hs_f, vs_f, de_f;
  logic [2:0]  rgb_s, rgb_f;

  int checks = 0, failures = 0;
  int n = 0;
  bit rand_en = 1'b0;
  int tick_n[$];
  int sbx[32], sby[32], spy[32];

  always #5 clk = ~clk;

  pong_pixel_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .PAD_H(PH)
  ) dut (
    .clk_pix_i(clk), .rst_n_i(rst_n), .ball_i(ball_s), .pad_i(pad_s),
    .frame_tick_o(tick_s), .hsync_o(hs_s), .vsync_o(vs_s), .de_o(de_s), .rgb_o(rgb_s)
  );

  pong_pixel_gen dut_full (
    .clk_pix_i(clk), .rst_n_i(rst_n), .ball_i(ball_f), .pad_i(pad_f),
    .frame_tick_o(tick_f), .hsync_o(hs_f), .vsync_o(vs_f), .de_o(de_f), .rgb_o(rgb_f)
  );

  // Expected {tick,hsync,vsync,de,rgb} for cycle n after reset release.
  function automatic logic [6:0] ref_px(int cyc, int ha, int hfp, int hs, int hbp,
                                        int va, int vfp, int vs, int vbp, int padh,
                                        int bx, int by, int py);
    int p, ht, vt, h, v;
    logic t, hsy, vsy, de;
    logic [2:0] c;
    p = cyc - 2;
    if (p < 0) return RST_VAL;
    ht  = ha + hfp + hs + hbp;
    vt  = va + vfp + vs + vbp;
    h   = p % ht;
    v   = (p / ht) % vt;
    t   = (h == 0) && (v == va);
    hsy = !((h >= ha + hfp) && (h < ha + hfp + hs));
    vsy = !((v >= va + vfp) && (v < va + vfp + vs));
    de  = (h < ha) && (v < va);
    c   = 3'b000;
    if (de) begin
      if (h >= bx && h < bx + 8 && v >= by && v < by + 8) c = 3'b111;
      else if (h >= 16 && h < 24 && v >= py && v < py + padh) c = 3'b010;
    end
    return {t, hsy, vsy, de, c};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  task automatic clear_snaps();
    for (int i = 0; i < 32; i++) begin
      sbx[i] = 0; sby[i] = 0; spy[i] = 0;
    end
  endtask

  task automatic set_ball(int bx, int by, int py);
    ball_s = {10'(bx), 10'(by)};
    pad_s  = {10'($urandom_range(0, 1023)), 10'(py)};
  endtask

  // Called at the negedge of cycle n: check outputs, drive inputs, advance.
  task automatic step();
    logic [6:0] e;
    int f;
    f = (n >= 2) ? ((n - 2) / FT) : 0;
    if (f > 31) f = 31;
    e = ref_px(n, HA, HFP, HSY, HBP, VA, VFP, VSY, VBP, PH, sbx[f], sby[f], spy[f]);
    check("small_timing", {tick_s, hs_s, vs_s, de_s}, e[6:3]);
    check("small_rgb", rgb_s, e[2:0]);
    if (n < 1700) begin
      e = ref_px(n, 640, 16, 96, 48, 480, 10, 2, 33, 64, 0, 0, 0);
      check("full_outputs", {tick_f, hs_f, vs_f, de_f, rgb_f}, e);
    end
    if (tick_s) tick_n.push_back(n);
    if (rand_en && $urandom_range(0, 499) == 0) begin
      if ($urandom_range(0, 3) == 0)
        set_ball($urandom_range(1012, 1023), $urandom_range(0, 58), $urandom_range(0, 50));
      else
        set_ball($urandom_range(0, 75), $urandom_range(0, 58), $urandom_range(0, 50));
    end
    if ((n % FT) == SNAP && (n / FT) + 1 < 32) begin
      sbx[(n / FT) + 1] = int'(ball_s[19:10]);
      sby[(n / FT) + 1] = int'(ball_s[9:0]);
      spy[(n / FT) + 1] = int'(pad_s[9:0]);
    end
    n++;
    @(negedge clk);
  endtask

  task automatic run_until(int stop_n);
    while (n < stop_n) step();
  endtask

  initial begin
    int target, start;
    clear_snaps();
    // reset state
    repeat (3) @(negedge clk);
    check("rst_small", {tick_s, hs_s, vs_s, de_s, rgb_s}, RST_VAL);
    check("rst_full", {tick_f, hs_f, vs_f, de_f, rgb_f}, RST_VAL);

    // ball/pad set before the first tick; visible from frame 1
    set_ball(10, 5, 20);
    rst_n = 1'b1;
    n = 0;
    run_until(3 * FT + 400);

    // tick spacing over three frames
    check("tick_count", tick_n.size(), 3);
    if (tick_n.size() == 3) begin
      check("tick_first", tick_n[0], SNAP + 2);
      check("tick_period1", tick_n[1] - tick_n[0], FT);
      check("tick_period2", tick_n[2] - tick_n[1], FT);
    end

    // ball over paddle, far-right ball (no wrap), partially off-screen ball
    set_ball(16, 20, 20);
    run_until(4 * FT + 400);
    set_ball(1020, 0, 0);
    run_until(5 * FT + 400);
    set_ball(60, 44, 40);
    run_until(6 * FT + 400);

    // random positions changing at random points mid-frame
    rand_en = 1'b1;
    run_until(9 * FT + 400);
    rand_en = 1'b0;

    // mid-frame reset with no clock edge, then timing restarts
    target = 30 * (HA + HFP + HSY + HBP) + 40;
    start = n;
    while ((n % FT) != target && n < start + FT + 1) step();
    check("reset_point_reached", n % FT, target);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_small", {tick_s, hs_s, vs_s, de_s, rgb_s}, RST_VAL);
    check("midrst_full", {tick_f, hs_f, vs_f, de_f, rgb_f}, RST_VAL);
    repeat (3) @(negedge clk);
    check("midrst_hold", {tick_s, hs_s, vs_s, de_s, rgb_s}, RST_VAL);
    clear_snaps();
    tick_n.delete();
    set_ball(30, 10, 8);
    rst_n = 1'b1;
    n = 0;
    run_until(FT + 600);
    check("tick_after_reset_count", tick_n.size(), 1);
    if (tick_n.size() == 1) check("tick_after_reset_pos", tick_n[0], SNAP + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
